// File: rtl/box_slot_scheduler.sv
// Frame-synchronous bounding-box slot scheduler for the display overlay.
// Collects size-filtered boxes per frame into shadow slots and commits them
// atomically on the vsync leading edge, with hold-over for empty frames.
// Ports: pixelclk/reset_n; en (sampled at commit); i_vsync; box_valid/
// box_ready stream with box_hl/hr/vt/vb; hcount_l/r1..4, vcount_l/r1..4
// active slots; number of active slots; overflow; frame_stb commit pulse.
module box_slot_scheduler #(
    parameter int   NUM_SLOTS   = 4,
    parameter int   MIN_W       = 8,
    parameter int   MIN_H       = 8,
    parameter int   HOLD_FRAMES = 2,
    parameter logic VS_POL      = 1'b1
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        i_vsync,
    input  logic        box_valid,
    output logic        box_ready,
    input  logic [11:0] box_hl,
    input  logic [11:0] box_hr,
    input  logic [11:0] box_vt,
    input  logic [11:0] box_vb,
    output logic [11:0] hcount_l1,
    output logic [11:0] hcount_l2,
    output logic [11:0] hcount_l3,
    output logic [11:0] hcount_l4,
    output logic [11:0] hcount_r1,
    output logic [11:0] hcount_r2,
    output logic [11:0] hcount_r3,
    output logic [11:0] hcount_r4,
    output logic [11:0] vcount_l1,
    output logic [11:0] vcount_l2,
    output logic [11:0] vcount_l3,
    output logic [11:0] vcount_l4,
    output logic [11:0] vcount_r1,
    output logic [11:0] vcount_r2,
    output logic [11:0] vcount_r3,
    output logic [11:0] vcount_r4,
    output logic [3:0]  number,
    output logic        overflow,
    output logic        frame_stb
);

    localparam int HW = $clog2(HOLD_FRAMES + 2);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMMIT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic          vs_d;
    logic          vs_edge;
    logic [2:0]    sh_cnt;
    logic          ovf_flag;
    logic [HW-1:0] hold_cnt;
    logic [2:0]    act_cnt;

    logic [11:0] sh_hl [NUM_SLOTS];
    logic [11:0] sh_hr [NUM_SLOTS];
    logic [11:0] sh_vt [NUM_SLOTS];
    logic [11:0] sh_vb [NUM_SLOTS];

    logic [11:0] act_hl [NUM_SLOTS];
    logic [11:0] act_hr [NUM_SLOTS];
    logic [11:0] act_vt [NUM_SLOTS];
    logic [11:0] act_vb [NUM_SLOTS];

    logic        ordered;
    logic [11:0] box_w;
    logic [11:0] box_h;
    logic        box_ok;
    logic        take;
    logic        full;
    logic        store;
    logic        commit;

    assign vs_edge = (i_vsync == VS_POL) && (vs_d != VS_POL);

    always_comb begin
        state_d   = state_q;
        box_ready = 1'b0;
        frame_stb = 1'b0;
        unique case (state_q)
            IDLE: begin
                box_ready = 1'b1;
                if (vs_edge) state_d = COLLECT;
            end
            COLLECT: begin
                box_ready = 1'b1;
                if (vs_edge) state_d = COMMIT;
            end
            COMMIT: begin
                frame_stb = 1'b1;
                state_d   = COLLECT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Widths are only meaningful once ordering holds, so no wrap reaches box_ok.
    assign ordered = (box_hr > box_hl) && (box_vb > box_vt);
    assign box_w   = box_hr - box_hl;
    assign box_h   = box_vb - box_vt;
    assign box_ok  = ordered
                   && (box_w >= 12'(MIN_W))
                   && (box_h >= 12'(MIN_H));

    // IDLE also handshakes, but those boxes belong to a partial frame.
    assign take   = box_valid && box_ready
                  && (state_q == COLLECT) && box_ok;
    assign full   = (sh_cnt >= 3'(NUM_SLOTS));
    assign store  = take && !full;
    assign commit = (state_q == COMMIT);

    always_ff @(posedge pixelclk) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (store && (sh_cnt == 3'(i))) begin
                sh_hl[i] <= box_hl;
                sh_hr[i] <= box_hr;
                sh_vt[i] <= box_vt;
                sh_vb[i] <= box_vb;
            end
        end
    end

    always_ff @(posedge pixelclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            vs_d     <= ~VS_POL;
            sh_cnt   <= '0;
            ovf_flag <= 1'b0;
            hold_cnt <= '0;
            act_cnt  <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                act_hl[i] <= '0;
                act_hr[i] <= '0;
                act_vt[i] <= '0;
                act_vb[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vs_d    <= i_vsync;
            if (commit) begin
                overflow <= ovf_flag;
                ovf_flag <= 1'b0;
                sh_cnt   <= '0;
                if (!en || (sh_cnt != 3'd0)) begin
                    hold_cnt <= '0;
                    act_cnt  <= en ? sh_cnt : 3'd0;
                    // Unused slots go to zero: strict compares draw nothing.
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (en && (3'(i) < sh_cnt)) begin
                            act_hl[i] <= sh_hl[i];
                            act_hr[i] <= sh_hr[i];
                            act_vt[i] <= sh_vt[i];
                            act_vb[i] <= sh_vb[i];
                        end else begin
                            act_hl[i] <= '0;
                            act_hr[i] <= '0;
                            act_vt[i] <= '0;
                            act_vb[i] <= '0;
                        end
                    end
                end else if (hold_cnt < HW'(HOLD_FRAMES)) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end else begin
                    act_cnt <= '0;
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        act_hl[i] <= '0;
                        act_hr[i] <= '0;
                        act_vt[i] <= '0;
                        act_vb[i] <= '0;
                    end
                end
            end else if (take) begin
                if (!full) sh_cnt   <= sh_cnt + 3'd1;
                else       ovf_flag <= 1'b1;
            end
        end
    end

    assign number    = {1'b0, act_cnt};
    assign hcount_l1 = act_hl[0];
    assign hcount_l2 = act_hl[1];
    assign hcount_l3 = act_hl[2];
    assign hcount_l4 = act_hl[3];
    assign hcount_r1 = act_hr[0];
    assign hcount_r2 = act_hr[1];
    assign hcount_r3 = act_hr[2];
    assign hcount_r4 = act_hr[3];
    assign vcount_l1 = act_vt[0];
    assign vcount_l2 = act_vt[1];
    assign vcount_l3 = act_vt[2];
    assign vcount_l4 = act_vt[3];
    assign vcount_r1 = act_vb[0];
    assign vcount_r2 = act_vb[1];
    assign vcount_r3 = act_vb[2];
    assign vcount_r4 = act_vb[3];

endmodule

// File: tb/tb_box_slot_scheduler.sv
// Scoreboard bench for box_slot_scheduler: a frame-level reference model
// queues the expected overlay per commit; a monitor checks every cycle.
module tb_box_slot_scheduler;

    localparam logic VS_POL = 1'b1;

    logic        pixelclk = 1'b0;
    logic        reset_n  = 1'b0;
    logic        en       = 1'b1;
    logic        i_vsync  = ~VS_POL;
    logic        box_valid = 1'b0;
    logic [11:0] box_hl = '0;
    logic [11:0] box_hr = '0;
    logic [11:0] box_vt = '0;
    logic [11:0] box_vb = '0;
    logic        box_ready;
    logic [11:0] hcount_l1, hcount_l2, hcount_l3, hcount_l4;
    logic [11:0] hcount_r1, hcount_r2, hcount_r3, hcount_r4;
    logic [11:0] vcount_l1, vcount_l2, vcount_l3, vcount_l4;
    logic [11:0] vcount_r1, vcount_r2, vcount_r3, vcount_r4;
    logic [3:0]  number;
    logic        overflow;
    logic        frame_stb;

    always #5 pixelclk = ~pixelclk;

    box_slot_scheduler dut (
        .pixelclk (pixelclk),
        .reset_n  (reset_n),
        .en       (en),
        .i_vsync  (i_vsync),
        .box_valid(box_valid),
        .box_ready(box_ready),
        .box_hl   (box_hl),
        .box_hr   (box_hr),
        .box_vt   (box_vt),
        .box_vb   (box_vb),
        .hcount_l1(hcount_l1),
        .hcount_l2(hcount_l2),
        .hcount_l3(hcount_l3),
        .hcount_l4(hcount_l4),
        .hcount_r1(hcount_r1),
        .hcount_r2(hcount_r2),
        .hcount_r3(hcount_r3),
        .hcount_r4(hcount_r4),
        .vcount_l1(vcount_l1),
        .vcount_l2(vcount_l2),
        .vcount_l3(vcount_l3),
        .vcount_l4(vcount_l4),
        .vcount_r1(vcount_r1),
        .vcount_r2(vcount_r2),
        .vcount_r3(vcount_r3),
        .vcount_r4(vcount_r4),
        .number   (number),
        .overflow (overflow),
        .frame_stb(frame_stb)
    );

    typedef struct packed {
        logic [11:0] hl;
        logic [11:0] hr;
        logic [11:0] vt;
        logic [11:0] vb;
    } box_t;

    typedef struct packed {
        logic [3:0][11:0] hl;
        logic [3:0][11:0] hr;
        logic [3:0][11:0] vt;
        logic [3:0][11:0] vb;
        logic [3:0]       number;
        logic             ovf;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_cur  = '0;
    box_t stim_q[$];
    box_t frame_boxes[$];
    bit   armed    = 1'b0;
    int   hold     = 0;
    exp_t disp     = '0;

    function automatic box_t mk(int hl, int hr, int vt, int vb);
        box_t b;
        b.hl = 12'(hl);
        b.hr = 12'(hr);
        b.vt = 12'(vt);
        b.vb = 12'(vb);
        return b;
    endfunction

    function automatic exp_t dut_out();
        exp_t o;
        o.hl     = {hcount_l4, hcount_l3, hcount_l2, hcount_l1};
        o.hr     = {hcount_r4, hcount_r3, hcount_r2, hcount_r1};
        o.vt     = {vcount_l4, vcount_l3, vcount_l2, vcount_l1};
        o.vb     = {vcount_r4, vcount_r3, vcount_r2, vcount_r1};
        o.number = number;
        o.ovf    = overflow;
        return o;
    endfunction

    task automatic check_out(input string name, input exp_t want);
        exp_t got;
        got = dut_out();
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%h want=%h t=%0t",
                     name, got, want, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic got,
                             input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%b want=%b t=%0t",
                     name, got, want, $time);
        end
    endtask

    // Frame-level reference: what the overlay should show after this edge.
    function automatic void model_edge(input bit en_v);
        box_t acc[$];
        int   n;
        if (!armed) begin
            armed = 1'b1;
            frame_boxes.delete();
            return;
        end
        foreach (frame_boxes[i]) begin
            box_t b;
            b = frame_boxes[i];
            if (int'(b.hr) > int'(b.hl) && int'(b.vb) > int'(b.vt) &&
                int'(b.hr) - int'(b.hl) >= 8 &&
                int'(b.vb) - int'(b.vt) >= 8)
                acc.push_back(b);
        end
        n = (acc.size() > 4) ? 4 : acc.size();
        if (!en_v || n > 0) begin
            disp = '0;
            hold = 0;
            if (en_v) begin
                for (int i = 0; i < n; i++) begin
                    disp.hl[i] = acc[i].hl;
                    disp.hr[i] = acc[i].hr;
                    disp.vt[i] = acc[i].vt;
                    disp.vb[i] = acc[i].vb;
                end
                disp.number = 4'(n);
            end
        end else if (hold < 2) begin
            hold++;
        end else begin
            disp = '0;
        end
        disp.ovf = (acc.size() > 4);
        exp_q.push_back(disp);
        frame_boxes.delete();
    endfunction

    task automatic drive_box(input box_t b);
        box_valid = 1'b1;
        box_hl    = b.hl;
        box_hr    = b.hr;
        box_vt    = b.vt;
        box_vb    = b.vb;
    endtask

    // Sends stim_q as one frame; optionally the last box rides the edge.
    task automatic send_frame(input bit en_v, input bit on_edge);
        box_t b;
        en = en_v;
        while (stim_q.size() > (on_edge ? 1 : 0)) begin
            @(negedge pixelclk);
            if ($urandom_range(3) == 0) begin
                box_valid = 1'b0;
                continue;
            end
            b = stim_q.pop_front();
            drive_box(b);
            frame_boxes.push_back(b);
        end
        @(negedge pixelclk);
        box_valid = 1'b0;
        repeat ($urandom_range(2)) @(negedge pixelclk);
        i_vsync = VS_POL;
        if (on_edge && stim_q.size() > 0) begin
            b = stim_q.pop_front();
            drive_box(b);
            frame_boxes.push_back(b);
        end
        model_edge(en_v);
        @(negedge pixelclk);
        box_valid = 1'b0;
        repeat (3) @(negedge pixelclk);
        i_vsync = ~VS_POL;
        repeat (2) @(negedge pixelclk);
    endtask

    task automatic mid_reset();
        @(negedge pixelclk);
        drive_box(mk(40, 90, 40, 90));
        @(negedge pixelclk);
        drive_box(mk(60, 120, 60, 120));
        @(negedge pixelclk);
        box_valid = 1'b0;
        reset_n   = 1'b0;
        armed     = 1'b0;
        hold      = 0;
        disp      = '0;
        mon_cur   = '0;
        frame_boxes.delete();
        #1;
        check_out("reset_async", '0);
        repeat (2) @(negedge pixelclk);
        reset_n = 1'b1;
    endtask

    task automatic rand_frame();
        int nb;
        nb = $urandom_range(0, 6);
        for (int i = 0; i < nb; i++) begin
            int hl, vt;
            hl = $urandom_range(10, 4000);
            vt = $urandom_range(10, 2000);
            stim_q.push_back(mk(hl, hl + $urandom_range(0, 24) - 3,
                                vt, vt + $urandom_range(0, 24) - 3));
        end
        send_frame($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1);
    endtask

    // Monitor: commit pulses pop the scoreboard; otherwise outputs hold.
    initial begin
        forever begin
            @(posedge pixelclk);
            #1;
            if (reset_n && frame_stb) begin
                check_bit("ready_low_in_commit", box_ready, 1'b0);
                @(posedge pixelclk);
                #1;
                check_bit("stb_one_cycle", frame_stb, 1'b0);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_commit: got=stb want=none");
                end else begin
                    mon_cur = exp_q.pop_front();
                    check_out("commit", mon_cur);
                end
            end else begin
                check_bit("ready_high", box_ready, 1'b1);
                check_out("stable", mon_cur);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge pixelclk);
        check_out("reset_state", '0);
        check_bit("reset_stb", frame_stb, 1'b0);
        check_bit("reset_ready", box_ready, 1'b1);
        reset_n = 1'b1;

        // Partial first frame: discarded, no commit.
        stim_q.push_back(mk(100, 200, 50, 150));
        send_frame(1'b1, 1'b0);

        stim_q.push_back(mk(100, 200, 50, 150));
        stim_q.push_back(mk(300, 340, 10, 40));
        stim_q.push_back(mk(0, 8, 0, 8));
        send_frame(1'b1, 1'b0);

        for (int i = 0; i < 6; i++)
            stim_q.push_back(mk(10 * i, 10 * i + 20, 5 * i, 5 * i + 30));
        send_frame(1'b1, 1'b0);

        stim_q.push_back(mk(500, 600, 400, 480));
        send_frame(1'b1, 1'b0);

        stim_q.push_back(mk(200, 200, 0, 50));
        stim_q.push_back(mk(210, 200, 0, 50));
        stim_q.push_back(mk(0, 5, 0, 50));
        stim_q.push_back(mk(0, 50, 0, 7));
        stim_q.push_back(mk(0, 7, 0, 50));
        send_frame(1'b1, 1'b0);

        stim_q.push_back(mk(11, 33, 22, 44));
        stim_q.push_back(mk(1000, 1100, 700, 800));
        send_frame(1'b1, 1'b0);
        repeat (3) send_frame(1'b1, 1'b0);

        stim_q.push_back(mk(70, 90, 70, 90));
        stim_q.push_back(mk(4000, 4095, 2000, 2100));
        send_frame(1'b1, 1'b1);

        stim_q.push_back(mk(70, 90, 70, 90));
        stim_q.push_back(mk(80, 99, 80, 99));
        send_frame(1'b0, 1'b0);

        mid_reset();
        stim_q.push_back(mk(300, 400, 300, 400));
        send_frame(1'b1, 1'b0);
        stim_q.push_back(mk(123, 234, 111, 222));
        stim_q.push_back(mk(5, 15, 5, 15));
        send_frame(1'b1, 1'b0);

        repeat (60) rand_frame();

        repeat (5) @(negedge pixelclk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_commit: got=%0d pending want=0",
                     exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
